// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM link: duty scale and the measurement state encoding.
package pwm_pkg;

   localparam int DUTY_STEPS = 8;
   localparam int DUTY_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MEASURE = 2'd1,
      ST_STUCK   = 2'd2
   } pwm_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Result bus of the PWM capture block: measured period/high time, duty and status.
interface pwm_capture_if #(
   parameter int CNT_W = 16
);
   import pwm_pkg::*;

   logic [CNT_W-1:0]  period_cnt;
   logic [CNT_W-1:0]  high_cnt;
   logic [DUTY_W-1:0] duty8;
   logic              meas_valid;
   logic              stuck;

   modport master (
      output period_cnt, high_cnt, duty8, meas_valid, stuck
   );

   modport slave (
      input period_cnt, high_cnt, duty8, meas_valid, stuck
   );

endinterface

// File: rtl/pwm_sync.sv
// Synchroniser for the asynchronous PWM input plus a one-cycle delayed copy for edge detection.
module pwm_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic s,
   output logic rise
);

   logic [SYNC_STAGES-1:0] chain_q, chain_d;
   logic                   s_dly_q, s_dly_d;

   // Shift the input through the chain; the delayed copy follows the last stage.
   always_comb begin
      chain_d = {chain_q[SYNC_STAGES-2:0], din};
      s_dly_d = chain_q[SYNC_STAGES-1];
   end

   // Synchroniser registers, cleared by reset or soft clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain_q <= '0;
         s_dly_q <= 1'b0;
      end else begin
         chain_q <= chain_d;
         s_dly_q <= s_dly_d;
      end
   end

   assign s    = chain_q[SYNC_STAGES-1];
   assign rise = s & ~s_dly_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period, high time and duty (eighths) of an asynchronous PWM input,
// and reports a stuck input after TIMEOUT cycles without a rising edge.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int TIMEOUT     = 65535,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              en,
   input  logic              pwm_in,
   pwm_capture_if.master     res
);

   localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
   localparam int               CMP_W = CNT_W + 5;

   // Count k in 1..8 with 16*h >= (2k-1)*p: round-half-up of 8*h/p without a divider.
   function automatic logic [DUTY_W-1:0] duty_eighths(input logic [CNT_W-1:0] h,
                                                       input logic [CNT_W-1:0] p);
      logic [CMP_W-1:0]  h16;
      logic [CMP_W-1:0]  pk;
      logic [DUTY_W-1:0] n;
      n   = '0;
      h16 = CMP_W'({h, 4'b0000});
      for (int k = 1; k <= DUTY_STEPS; k++) begin
         pk = CMP_W'(p) * CMP_W'(2 * k - 1);
         if (h16 >= pk) n = n + DUTY_W'(1);
      end
      return n;
   endfunction

   logic sync_rst;
   logic s;
   logic rise;

   assign sync_rst = rst | clr;

   pwm_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .rst  (sync_rst),
      .din  (pwm_in),
      .s    (s),
      .rise (rise)
   );

   pwm_state_e        state_q,  state_d;
   logic [CNT_W-1:0]  pctr_q,   pctr_d;
   logic [CNT_W-1:0]  hctr_q,   hctr_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic [CNT_W-1:0]  high_q,   high_d;
   logic [DUTY_W-1:0] duty_q,   duty_d;
   logic              valid_q,  valid_d;
   logic              stuck_q,  stuck_d;

   // Next state: counting, measurement on rise, timeout detection; rise wins over timeout.
   always_comb begin
      state_d  = state_q;
      pctr_d   = pctr_q;
      hctr_d   = hctr_q;
      period_d = period_q;
      high_d   = high_q;
      duty_d   = duty_q;
      stuck_d  = stuck_q;
      valid_d  = 1'b0;

      if (!en) begin
         state_d = ST_IDLE;
      end else begin
         if (pctr_q != TMO) pctr_d = pctr_q + ONE;
         if (state_q == ST_MEASURE) hctr_d = hctr_q + CNT_W'(s);

         if (rise) begin
            if (state_q == ST_MEASURE) begin
               period_d = pctr_q;
               high_d   = hctr_q;
               duty_d   = duty_eighths(hctr_q, pctr_q);
               stuck_d  = 1'b0;
               valid_d  = 1'b1;
            end
            pctr_d  = ONE;
            hctr_d  = ONE;
            state_d = ST_MEASURE;
         end else if ((state_q != ST_STUCK) && (pctr_q == TMO)) begin
            // Hold hctr so it can never run past the saturated period counter.
            hctr_d   = hctr_q;
            period_d = '0;
            high_d   = '0;
            duty_d   = s ? DUTY_W'(DUTY_STEPS) : '0;
            stuck_d  = 1'b1;
            valid_d  = 1'b1;
            state_d  = ST_STUCK;
         end
      end
   end

   // State, counters and output registers; reset and soft clear return everything to zero.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state_q  <= ST_IDLE;
         pctr_q   <= '0;
         hctr_q   <= '0;
         period_q <= '0;
         high_q   <= '0;
         duty_q   <= '0;
         valid_q  <= 1'b0;
         stuck_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         pctr_q   <= pctr_d;
         hctr_q   <= hctr_d;
         period_q <= period_d;
         high_q   <= high_d;
         duty_q   <= duty_d;
         valid_q  <= valid_d;
         stuck_q  <= stuck_d;
      end
   end

   assign res.period_cnt = period_q;
   assign res.high_cnt   = high_q;
   assign res.duty8      = duty_q;
   assign res.meas_valid = valid_q;
   assign res.stuck      = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: segment-level reference model (each PWM segment = high h, low l)
// predicts the ordered list of result pulses; a monitor compares every pulse.
module tb_pwm_capture;

   localparam int CNT_W = 16;
   localparam int TMO   = 32;
   localparam int EXT   = 40;

   logic clk = 1'b0;
   logic rst, clr, en, pwm_in;

   pwm_capture_if #(.CNT_W(CNT_W)) bus ();

   pwm_capture #(
      .CNT_W       (CNT_W),
      .TIMEOUT     (TMO),
      .SYNC_STAGES (2)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .en     (en),
      .pwm_in (pwm_in),
      .res    (bus.master)
   );

   always #5 clk = ~clk;

   typedef struct {
      int p;
      int h;
      int d;
      bit st;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   bit   armed       = 1'b0;
   int   cur_h       = 0;
   int   cur_l       = 0;

   // Round-half-up of 8*h/p.
   function automatic int duty_ref(input int h, input int p);
      return (16 * h + p) / (2 * p);
   endfunction

   function automatic void push_meas(input int h, input int p);
      exp_t e;
      e.p = p; e.h = h; e.d = duty_ref(h, p); e.st = 1'b0;
      exp_q.push_back(e);
   endfunction

   function automatic void push_stuck(input bit high_level);
      exp_t e;
      e.p = 0; e.h = 0; e.d = high_level ? 8 : 0; e.st = 1'b1;
      exp_q.push_back(e);
   endfunction

   // A new rising edge: closes the previous segment (if it had a reference rise and did not
   // time out) and opens a new one; a segment longer than TMO times out at offset TMO.
   function automatic void open_seg(input int h, input int l);
      if (armed && (cur_h + cur_l) <= TMO) push_meas(cur_h, cur_h + cur_l);
      armed = 1'b1;
      cur_h = h;
      cur_l = l;
      if (h + l > TMO) push_stuck(h > TMO);
   endfunction

   task automatic hold(input logic v, input int n);
      pwm_in = v;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_seg(input int h, input int l);
      open_seg(h, l);
      hold(1'b1, h);
      hold(1'b0, l);
   endtask

   // Extend the last low phase past the timeout, then require every predicted pulse seen.
   task automatic end_stream(input string tag);
      if (armed && (cur_h + cur_l) <= TMO) push_stuck(cur_h > TMO);
      hold(1'b0, EXT);
      armed = 1'b0;
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL %s_pending: %0d expected pulses never seen, required 0", tag, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic check_outputs(input string tag, input int p, input int h, input int d,
                                input bit st, input bit vld);
      vectors++;
      if (bus.period_cnt !== 16'(p) || bus.high_cnt !== 16'(h) || bus.duty8 !== 4'(d) ||
          bus.stuck !== st || bus.meas_valid !== vld) begin
         miscompares++;
         $display("FAIL %s: got p=%0d h=%0d d=%0d st=%0b v=%0b, required p=%0d h=%0d d=%0d st=%0b v=%0b",
                  tag, bus.period_cnt, bus.high_cnt, bus.duty8, bus.stuck, bus.meas_valid,
                  p, h, d, st, vld);
      end
   endtask

   // Scoreboard: every result pulse must match the next predicted one.
   exp_t mon_e;
   always @(negedge clk) begin
      if (bus.meas_valid === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_pulse: got p=%0d h=%0d d=%0d st=%0b, required no pulse",
                     bus.period_cnt, bus.high_cnt, bus.duty8, bus.stuck);
         end else begin
            mon_e = exp_q.pop_front();
            if (bus.period_cnt !== 16'(mon_e.p) || bus.high_cnt !== 16'(mon_e.h) ||
                bus.duty8 !== 4'(mon_e.d) || bus.stuck !== mon_e.st) begin
               miscompares++;
               $display("FAIL pulse_value: got p=%0d h=%0d d=%0d st=%0b, required p=%0d h=%0d d=%0d st=%0b",
                        bus.period_cnt, bus.high_cnt, bus.duty8, bus.stuck,
                        mon_e.p, mon_e.h, mon_e.d, mon_e.st);
            end
         end
      end
   end

   task automatic test_reset();
      rst = 1'b1; clr = 1'b0; en = 1'b1;
      hold(1'b0, 3);
      check_outputs("reset_state", 0, 0, 0, 1'b0, 1'b0);
      rst = 1'b0;
      // No edge after reset: IDLE times out with the input low.
      armed = 1'b0;
      push_stuck(1'b0);
      hold(1'b0, EXT);
      check_outputs("idle_timeout", 0, 0, 0, 1'b1, 1'b0);
      end_stream("reset");
   endtask

   task automatic test_basic();
      for (int i = 0; i < 5; i++) drive_seg(4, 4);
      check_outputs("basic_4_4", 8, 4, 4, 1'b0, 1'b0);
      end_stream("basic");
   endtask

   task automatic test_duty();
      int hs[9] = '{1, 3, 7, 1, 1, 15, 16, 16, 5};
      int ls[9] = '{7, 4, 1, 15, 16, 1, 16, 17, 3};
      for (int i = 0; i < 9; i++) drive_seg(hs[i], ls[i]);
      drive_seg(4, 4);
      check_outputs("duty_5_8", 8, 5, 5, 1'b0, 1'b0);
      end_stream("duty");
   endtask

   task automatic test_timeout();
      drive_seg(4, 4);
      drive_seg(4, 4);
      drive_seg(60, 40);
      check_outputs("stuck_high", 0, 0, 8, 1'b1, 1'b0);
      drive_seg(4, 4);
      drive_seg(2, 50);
      check_outputs("stuck_low", 0, 0, 0, 1'b1, 1'b0);
      drive_seg(4, 4);
      drive_seg(4, 4);
      check_outputs("resume", 8, 4, 4, 1'b0, 1'b0);
      end_stream("timeout");
   endtask

   task automatic test_clr();
      for (int i = 0; i < 3; i++) drive_seg(4, 4);
      open_seg(4, 4);
      hold(1'b1, 4);
      hold(1'b0, 2);
      clr = 1'b1;
      hold(1'b0, 1);
      clr = 1'b0;
      armed = 1'b0;
      check_outputs("clr_zero", 0, 0, 0, 1'b0, 1'b0);
      hold(1'b0, 2);
      for (int i = 0; i < 3; i++) drive_seg(4, 4);
      check_outputs("after_clr", 8, 4, 4, 1'b0, 1'b0);
      end_stream("clr");
   endtask

   task automatic test_enable();
      for (int i = 0; i < 3; i++) drive_seg(4, 4);
      open_seg(4, 4);
      hold(1'b1, 4);
      hold(1'b0, 2);
      en = 1'b0;
      armed = 1'b0;
      hold(1'b0, 2);
      for (int i = 0; i < 4; i++) begin
         hold(1'b1, 4);
         hold(1'b0, 4);
      end
      hold(1'b1, 4);
      hold(1'b0, 2);
      check_outputs("en_hold", 8, 4, 4, 1'b0, 1'b0);
      en = 1'b1;
      hold(1'b0, 2);
      drive_seg(4, 4);
      drive_seg(4, 4);
      drive_seg(4, 4);
      end_stream("enable");
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) drive_seg(4, 4);
      open_seg(8, 4);
      hold(1'b1, 5);
      rst = 1'b1;
      hold(1'b1, 1);
      rst = 1'b0;
      check_outputs("rst_mid_high", 0, 0, 0, 1'b0, 1'b0);
      // The synchroniser restarts low, so the remaining high phase reads as a fresh edge.
      armed = 1'b1; cur_h = 3; cur_l = 4;
      hold(1'b1, 3);
      hold(1'b0, 4);
      drive_seg(4, 4);
      drive_seg(4, 4);
      check_outputs("after_rst", 8, 4, 4, 1'b0, 1'b0);
      // Clear lands on the very cycle the rise is recognised.
      hold(1'b1, 2);
      clr = 1'b1;
      hold(1'b1, 1);
      clr = 1'b0;
      check_outputs("rise_and_clr", 0, 0, 0, 1'b0, 1'b0);
      armed = 1'b1; cur_h = 2; cur_l = 6;
      hold(1'b1, 2);
      hold(1'b0, 6);
      drive_seg(4, 4);
      drive_seg(4, 4);
      end_stream("reset_mid");
   endtask

   task automatic test_random();
      int h, l, sel;
      for (int i = 0; i < 40; i++) begin
         sel = $urandom_range(0, 9);
         h = (sel == 1) ? $urandom_range(33, 45) : $urandom_range(1, 20);
         l = (sel == 0) ? $urandom_range(20, 45) : $urandom_range(1, 20);
         drive_seg(h, l);
      end
      end_stream("random");
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; en = 1'b1; pwm_in = 1'b0;
      test_reset();
      test_basic();
      test_duty();
      test_timeout();
      test_clr();
      test_enable();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "time limit");
   end

endmodule
